branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Execute-stage branch resolution combined with a fetch-stage dynamic predictor for the pipelined core. It holds a direct-mapped table of 2-bit saturating counters indexed by PC. Fetch gets a same-cycle taken/not-taken prediction. Execute evaluates all six RV32I branch conditions, flags mispredictions, trains the table and keeps performance counters.

## Interface
- DATA_WIDTH, 32, operand width for comparisons
- ADDR_WIDTH, 32, PC width
- BHT_ENTRIES, 64, number of counters; power of two, 2..1024
- IDX_LSB, 2, lowest PC bit used for the table index; index = PC[IDX_LSB +: log2(BHT_ENTRIES)]
- CNT_WIDTH, 32, width of the performance counters
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- FetchPC_i  input  ADDR_WIDTH  PC being fetched
- PredictTaken_o  output  1  prediction for FetchPC_i
- ExBranch_i  input  1  execute stage holds a valid conditional branch
- Stall_i  input  1  execute stage frozen this cycle; suppresses all state updates
- ExPC_i  input  ADDR_WIDTH  PC of the branch in execute
- ExPredTaken_i  input  1  prediction made at fetch for this branch, carried down the pipe
- funct3_i  input  3  branch type
- SrcA_i, SrcB_i  input  DATA_WIDTH  operands
- BranchTaken_o  output  1  resolved outcome
- Mispredict_o  output  1  resolved outcome differs from ExPredTaken_i
- IllegalBranch_o  output  1  registered one-cycle pulse for funct3 010/011
- BranchCount_o  output  CNT_WIDTH  branches resolved since reset
- MispredictCount_o  output  CNT_WIDTH  mispredictions since reset

## Operation
- Outcome decode:
  - 000 BEQ: A==B
  - 001 BNE: A!=B
  - 100 BLT: signed A<B
  - 101 BGE: signed A>=B
  - 110 BLTU: unsigned A<B
  - 111 BGEU: unsigned A>=B
  - 010/011: outcome 0
- BranchTaken_o and Mispredict_o are forced to 0 when ExBranch_i=0 or funct3 is illegal.
- Mispredict_o = BranchTaken_o XOR ExPredTaken_i, gated as above. It is combinational and is not gated by Stall_i.
- Each table entry is a 4-state FSM: SNT(00), WNT(01), WT(10), ST(11).
  - Taken moves one state toward ST.
  - Not-taken moves one state toward SNT.
  - The FSM saturates at both ends.
- PredictTaken_o = MSB of entry[index(FetchPC_i)].
- Update condition: ExBranch_i=1, Stall_i=0 and funct3 legal. When met:
  - entry[index(ExPC_i)] is written at the rising edge.
  - BranchCount_o increments.
  - MispredictCount_o increments if Mispredict_o=1.
- Performance counters saturate at all-ones and do not wrap.
- IllegalBranch_o is set at the edge when ExBranch_i=1, Stall_i=0 and funct3 is 010/011. It clears on the next edge.

## Timing
- Prediction: combinational from FetchPC_i, zero cycles.
- Resolution: combinational from the execute inputs, zero cycles.
- Training: the table write becomes visible to PredictTaken_o from the cycle after the update edge.
- Same-index collision: when fetch reads the index being updated in the same cycle, it sees the old value. There is no bypass.
- Stall_i=1 holds the table, both counters and IllegalBranch_o (it reads 0) unchanged for any number of cycles.
- Reset asserted asynchronously, including mid-update:
  - every table entry returns to WNT (01), so PredictTaken_o=0
  - both counters return to 0
  - IllegalBranch_o returns to 0
- Reset release: the first update can occur at the first rising edge after rst_i falls.

## Structure
- Package branch_pkg holds:
  - the enum bp_state_t (SNT/WNT/WT/ST)
  - localparams for the six branch funct3 encodings
  - a saturating next-state function
- Sub-module branch_cmp holds the combinational funct3/operand comparison, parametrised by DATA_WIDTH.
- The table is a flop array (not RAM), because reset must clear every entry and the read is asynchronous.
- The index width is $clog2(BHT_ENTRIES). An elaboration-time assertion rejects a BHT_ENTRIES value that is not a power of two.

## Test plan
- Reset, then FetchPC_i=0x100 → PredictTaken_o=0. Both counters read 0.
- Signed/unsigned compare, A=0xFFFFFFFF, B=1:
  - BLT → taken; BGE → not taken
  - BLTU → not taken; BGEU → taken
  - BEQ with A=B=5 → taken; BNE → not taken
- Training at PC 0x40:
  - resolve BEQ taken twice with ExPredTaken_i=0 → Mispredict_o=1 both times
  - FetchPC_i=0x40 then gives PredictTaken_o=1 (WNT→WT→ST)
  - MispredictCount_o=2, BranchCount_o=2
  - two not-taken resolutions return the prediction to 0
- Aliasing: with BHT_ENTRIES=64, training PC 0x40 also moves the prediction for PC 0x140. Fetching the updated index in the update cycle returns the old prediction.
- Stall and illegal funct3:
  - ExBranch_i=1 with Stall_i=1 for 3 cycles → table and counters unchanged
  - funct3=010 → BranchTaken_o=0, IllegalBranch_o pulses for one cycle, no table or count change
- Reset mid-run: assert rst_i between edges after training PC 0x40 to ST → PredictTaken_o drops to 0 immediately and counters clear.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared types, funct3 encodings and counter helpers for the branch predictor.
package branch_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} bp_state_t;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  function automatic bp_state_t bp_next(input bp_state_t s, input logic taken);
    return taken ? (s == ST ? ST : bp_state_t'(s + 2'd1)) : (s == SNT ? SNT : bp_state_t'(s - 2'd1));
  endfunction
  function automatic logic f3_legal(input logic [2:0] f);
    return f[2:1] != 2'b01;
  endfunction
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational RV32I branch condition evaluation.
module branch_cmp import branch_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  taken_o,
  output logic                  legal_o
);
  logic eq, lt, ltu;
  always_comb begin
    eq = a_i == b_i;
    lt = $signed(a_i) < $signed(b_i);
    ltu = a_i < b_i;
    legal_o = f3_legal(funct3_i);
    taken_o = funct3_i == F3_BEQ  ? eq :
              funct3_i == F3_BNE  ? ~eq :
              funct3_i == F3_BLT  ? lt :
              funct3_i == F3_BGE  ? ~lt :
              funct3_i == F3_BLTU ? ltu :
              funct3_i == F3_BGEU ? ~ltu : 1'b0;
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit saturating-counter predictor with execute-stage resolution,
// training and saturating performance counters.
module branch_predict_unit import branch_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] FetchPC_i,
  output logic                  PredictTaken_o,
  input  logic                  ExBranch_i,
  input  logic                  Stall_i,
  input  logic [ADDR_WIDTH-1:0] ExPC_i,
  input  logic                  ExPredTaken_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  output logic                  BranchTaken_o,
  output logic                  Mispredict_o,
  output logic                  IllegalBranch_o,
  output logic [CNT_WIDTH-1:0]  BranchCount_o,
  output logic [CNT_WIDTH-1:0]  MispredictCount_o
);
  localparam int IW = $clog2(BHT_ENTRIES);
  if (BHT_ENTRIES < 2 || BHT_ENTRIES > 1024 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("BHT_ENTRIES must be a power of two in 2..1024");
  end
  bp_state_t bht_q [BHT_ENTRIES];
  bp_state_t bht_d [BHT_ENTRIES];
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  logic ill_q, ill_d;
  logic [IW-1:0] fetch_idx, ex_idx;
  logic cmp_taken, cmp_legal, valid, upd;
  logic unused_pc;
  assign unused_pc = ^{FetchPC_i, ExPC_i};
  branch_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .funct3_i (funct3_i),
    .a_i      (SrcA_i),
    .b_i      (SrcB_i),
    .taken_o  (cmp_taken),
    .legal_o  (cmp_legal)
  );
  // Fetch and execute read independently; a same-cycle write is not bypassed to fetch.
  always_comb begin
    fetch_idx = FetchPC_i[IDX_LSB +: IW];
    ex_idx = ExPC_i[IDX_LSB +: IW];
    valid = ExBranch_i & cmp_legal;
    upd = valid & ~Stall_i;
    PredictTaken_o = bht_q[fetch_idx] >= WT;
    BranchTaken_o = valid & cmp_taken;
    Mispredict_o = valid & (cmp_taken ^ ExPredTaken_i);
    bht_d = bht_q;
    if (upd) bht_d[ex_idx] = bp_next(bht_q[ex_idx], cmp_taken);
    br_cnt_d = (upd && br_cnt_q != '1) ? br_cnt_q + 1'b1 : br_cnt_q;
    mis_cnt_d = (upd && Mispredict_o && mis_cnt_q != '1) ? mis_cnt_q + 1'b1 : mis_cnt_q;
    ill_d = ExBranch_i & ~Stall_i & ~cmp_legal;
    IllegalBranch_o = ill_q;
    BranchCount_o = br_cnt_q;
    MispredictCount_o = mis_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
      br_cnt_q <= '0;
      mis_cnt_q <= '0;
      ill_q <= 1'b0;
    end else begin
      bht_q <= bht_d;
      br_cnt_q <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      ill_q <= ill_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench with a behavioural predictor model.
module tb_branch_predict_unit;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] fpc = 0, expc = 0, sa = 0, sb = 0;
  logic br = 0, st = 0, pt = 0;
  logic [2:0] f3 = 0;
  logic pred, taken, mis, ill;
  logic [31:0] bc, mc;
  typedef struct {
    string tag;
    logic pred, taken, mis, ill;
    logic [31:0] bc, mc;
  } exp_t;
  exp_t q[$];
  int tbl [64];
  logic [31:0] m_bc, m_mc;
  logic m_ill;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  branch_predict_unit dut (
    .clk_i(clk), .rst_i(rst), .FetchPC_i(fpc), .PredictTaken_o(pred),
    .ExBranch_i(br), .Stall_i(st), .ExPC_i(expc), .ExPredTaken_i(pt),
    .funct3_i(f3), .SrcA_i(sa), .SrcB_i(sb), .BranchTaken_o(taken),
    .Mispredict_o(mis), .IllegalBranch_o(ill), .BranchCount_o(bc),
    .MispredictCount_o(mc)
  );
  function automatic int idx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction
  function automatic longint sval(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
  endfunction
  function automatic logic is_legal(input logic [2:0] f);
    return !(f == 3'd2 || f == 3'd3);
  endfunction
  function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sval(a) < sval(b);
      3'd5: return sval(a) >= sval(b);
      3'd6: return longint'(a) < longint'(b);
      3'd7: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 64; i++) tbl[i] = 1;
    m_bc = 0;
    m_mc = 0;
    m_ill = 0;
  endtask
  task automatic model_edge();
    logic t;
    if (rst) begin
      model_reset();
      return;
    end
    m_ill = br && !st && !is_legal(f3);
    if (br && !st && is_legal(f3)) begin
      t = ref_taken(f3, sa, sb);
      tbl[idx(expc)] = t ? (tbl[idx(expc)] < 3 ? tbl[idx(expc)] + 1 : 3) : (tbl[idx(expc)] > 0 ? tbl[idx(expc)] - 1 : 0);
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (t != pt && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
    end
  endtask
  task automatic step(input logic r, input logic b_, input logic s, input logic [31:0] fp,
                      input logic [31:0] ep, input logic p, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t e;
    logic g;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; br = b_; st = s; fpc = fp; expc = ep; pt = p; f3 = f; sa = a; sb = b;
    if (rst) model_reset();
    g = br && is_legal(f3);
    e.tag = tag;
    e.pred = tbl[idx(fpc)] >= 2;
    e.taken = g && ref_taken(f3, sa, sb);
    e.mis = g && (ref_taken(f3, sa, sb) != pt);
    e.ill = m_ill;
    e.bc = m_bc;
    e.mc = m_mc;
    q.push_back(e);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.tag, ".pred"}, 32'(pred), 32'(e.pred));
        chk({e.tag, ".taken"}, 32'(taken), 32'(e.taken));
        chk({e.tag, ".mis"}, 32'(mis), 32'(e.mis));
        chk({e.tag, ".ill"}, 32'(ill), 32'(e.ill));
        chk({e.tag, ".bc"}, bc, e.bc);
        chk({e.tag, ".mc"}, mc, e.mc);
      end
    end
  end
  initial begin
    logic [31:0] a, b;
    model_reset();
    step(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, "rst0");
    step(0, 0, 0, 32'h100, 0, 0, 0, 0, 0, "rst_state");
    step(0, 1, 0, 0, 32'h800, 0, 3'd4, 32'hFFFF_FFFF, 1, "blt");
    step(0, 1, 0, 0, 32'h804, 0, 3'd5, 32'hFFFF_FFFF, 1, "bge");
    step(0, 1, 0, 0, 32'h808, 0, 3'd6, 32'hFFFF_FFFF, 1, "bltu");
    step(0, 1, 0, 0, 32'h80C, 0, 3'd7, 32'hFFFF_FFFF, 1, "bgeu");
    step(0, 1, 0, 0, 32'h810, 0, 3'd0, 5, 5, "beq");
    step(0, 1, 0, 0, 32'h814, 0, 3'd1, 5, 5, "bne");
    step(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, "rst1");
    step(0, 1, 0, 32'h40, 32'h40, 0, 3'd0, 7, 7, "train1");
    step(0, 1, 0, 32'h40, 32'h40, 0, 3'd0, 7, 7, "train2");
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, "trained");
    step(0, 0, 0, 32'h140, 0, 0, 0, 0, 0, "alias");
    step(0, 1, 0, 32'h140, 32'h40, 1, 3'd1, 3, 3, "untrain1");
    step(0, 1, 0, 32'h40, 32'h40, 1, 3'd1, 3, 3, "untrain2");
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, "untrained");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h40, 32'h40, 0, 3'd0, 1, 1, "stall");
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, "post_stall");
    step(0, 1, 0, 32'h40, 32'h40, 0, 3'd2, 1, 1, "illegal");
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, "ill_pulse");
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, "ill_clear");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h40, 32'h40, 1, 3'd0, 9, 9, "to_st");
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, "at_st");
    step(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, "mid_rst");
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, "after_rst");
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : $urandom);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 8);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           32'(($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8)),
           32'(($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b, "rand");
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
